// File: rtl/ibex_instr_aligner_if.sv
// Handshake bundle between the prefetch buffer, the instruction aligner and the IF/ID register.
// The aligner connects through the slave modport; its environment uses the master modport.
interface ibex_instr_aligner_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_rdata_i;
    logic [31:0] in_addr_i;
    logic        in_err_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        out_is_compressed_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    modport master (
        output in_valid_i, in_rdata_i, in_addr_i, in_err_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_rdata_o, out_addr_o,
               out_is_compressed_o, out_err_o, out_err_plus2_o
    );

    modport slave (
        input  in_valid_i, in_rdata_i, in_addr_i, in_err_i, out_ready_i,
        output in_ready_o, out_valid_o, out_rdata_o, out_addr_o,
               out_is_compressed_o, out_err_o, out_err_plus2_o
    );
endinterface

// File: rtl/ibex_instr_aligner.sv
// RV32C instruction aligner: splits/joins 32-bit fetch words into whole 16/32-bit instructions,
// keeping at most one leftover halfword and presenting one registered instruction per cycle.
module ibex_instr_aligner #(
    parameter bit ZeroPadCompressed = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    ibex_instr_aligner_if.slave  bus,
    output logic                 busy_o
);
    logic        hold_v_q, hold_v_d;
    logic [15:0] hold_data_q, hold_data_d;
    logic [31:1] hold_addr_q, hold_addr_d;
    logic        hold_err_q, hold_err_d;

    logic        out_v_q;
    logic [31:0] out_rdata_q, out_rdata_d;
    logic [31:1] out_addr_q, out_addr_d;
    logic        out_c_q, out_c_d;
    logic        out_err_q, out_err_d;
    logic        out_p2_q, out_p2_d;

    logic        advance, go, emit, consume, hold_c;
    logic [15:0] in_lo, in_hi;
    logic [31:1] in_lo_addr, in_hi_addr;
    logic        unused_addr0;

    function automatic logic is_comp(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

    function automatic logic [31:0] comp_word(input logic [15:0] hw);
        return ZeroPadCompressed ? {16'h0000, hw} : {hw, hw};
    endfunction

    assign in_lo        = bus.in_rdata_i[15:0];
    assign in_hi        = bus.in_rdata_i[31:16];
    assign in_lo_addr   = {bus.in_addr_i[31:2], 1'b0};
    assign in_hi_addr   = {bus.in_addr_i[31:2], 1'b1};
    assign unused_addr0 = bus.in_addr_i[0];

    assign advance = ~out_v_q | bus.out_ready_i;
    assign go      = advance & ~clear_i & rst_ni;
    assign hold_c  = is_comp(hold_data_q);

    always_comb begin
        emit        = 1'b0;
        consume     = 1'b0;
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        hold_addr_d = hold_addr_q;
        hold_err_d  = hold_err_q;
        out_rdata_d = out_rdata_q;
        out_addr_d  = out_addr_q;
        out_c_d     = out_c_q;
        out_err_d   = out_err_q;
        out_p2_d    = out_p2_q;

        if (go) begin
            if (hold_v_q && hold_c) begin
                // Drain a compressed leftover before touching the input word.
                emit        = 1'b1;
                out_rdata_d = comp_word(hold_data_q);
                out_addr_d  = hold_addr_q;
                out_c_d     = 1'b1;
                out_err_d   = hold_err_q;
                out_p2_d    = 1'b0;
                hold_v_d    = 1'b0;
            end else if (hold_v_q) begin
                if (bus.in_valid_i) begin
                    emit        = 1'b1;
                    consume     = 1'b1;
                    out_rdata_d = {in_lo, hold_data_q};
                    out_addr_d  = hold_addr_q;
                    out_c_d     = 1'b0;
                    out_err_d   = hold_err_q | bus.in_err_i;
                    out_p2_d    = bus.in_err_i & ~hold_err_q;
                    hold_v_d    = 1'b1;
                    hold_data_d = in_hi;
                    hold_addr_d = in_hi_addr;
                    hold_err_d  = bus.in_err_i;
                end
            end else if (bus.in_valid_i) begin
                consume = 1'b1;
                if (!bus.in_addr_i[1]) begin
                    emit       = 1'b1;
                    out_addr_d = in_lo_addr;
                    out_err_d  = bus.in_err_i;
                    out_p2_d   = 1'b0;
                    if (is_comp(in_lo)) begin
                        out_rdata_d = comp_word(in_lo);
                        out_c_d     = 1'b1;
                        hold_v_d    = 1'b1;
                        hold_data_d = in_hi;
                        hold_addr_d = in_hi_addr;
                        hold_err_d  = bus.in_err_i;
                    end else begin
                        out_rdata_d = bus.in_rdata_i;
                        out_c_d     = 1'b0;
                    end
                end else if (is_comp(in_hi)) begin
                    emit        = 1'b1;
                    out_rdata_d = comp_word(in_hi);
                    out_addr_d  = in_hi_addr;
                    out_c_d     = 1'b1;
                    out_err_d   = bus.in_err_i;
                    out_p2_d    = 1'b0;
                end else begin
                    hold_v_d    = 1'b1;
                    hold_data_d = in_hi;
                    hold_addr_d = in_hi_addr;
                    hold_err_d  = bus.in_err_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_v_q    <= 1'b0;
            hold_data_q <= '0;
            hold_addr_q <= '0;
            hold_err_q  <= 1'b0;
            out_v_q     <= 1'b0;
            out_rdata_q <= '0;
            out_addr_q  <= '0;
            out_c_q     <= 1'b0;
            out_err_q   <= 1'b0;
            out_p2_q    <= 1'b0;
        end else if (clear_i) begin
            hold_v_q <= 1'b0;
            out_v_q  <= 1'b0;
        end else begin
            hold_v_q    <= hold_v_d;
            hold_data_q <= hold_data_d;
            hold_addr_q <= hold_addr_d;
            hold_err_q  <= hold_err_d;
            if (emit) begin
                out_v_q     <= 1'b1;
                out_rdata_q <= out_rdata_d;
                out_addr_q  <= out_addr_d;
                out_c_q     <= out_c_d;
                out_err_q   <= out_err_d;
                out_p2_q    <= out_p2_d;
            end else if (bus.out_ready_i) begin
                out_v_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o          = consume;
    assign bus.out_valid_o         = out_v_q;
    assign bus.out_rdata_o         = out_rdata_q;
    assign bus.out_addr_o          = {out_addr_q, 1'b0};
    assign bus.out_is_compressed_o = out_c_q;
    assign bus.out_err_o           = out_err_q;
    assign bus.out_err_plus2_o     = out_p2_q;
    assign busy_o                  = hold_v_q | out_v_q;
endmodule

// File: doc/ibex_instr_aligner.md
# ibex_instr_aligner

Instruction aligner stage between the prefetch buffer output (32-bit fetched words with address and error) and the IF/ID instruction register. It turns the halfword-granular RV32C fetch stream into whole instructions, one per cycle. Each output is either a 16-bit compressed instruction or a 32-bit instruction, which may straddle two fetch words. It holds at most one leftover halfword and presents instructions through a registered valid/ready output.

## Interface
- ZeroPadCompressed, default 1: when 1, `out_rdata_o[31:16]` is 0 for compressed instructions; when 0, it carries don't-care data.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- clear_i  input  1  flush on branch or exception; discards all held state.
- in_valid_i  input  1  fetch word valid.
- in_ready_o  output  1  word consumed this cycle.
- in_rdata_i  input  32  fetch word.
- in_addr_i  input  32  address of first useful halfword; bit 1 may be set after a branch; bit 0 is ignored.
- in_err_i  input  1  bus or PMP error for this word.
- out_valid_o  output  1  instruction valid (registered).
- out_ready_i  input  1  consumer accepts.
- out_rdata_o  output  32  instruction bits.
- out_addr_o  output  32  instruction PC; bit 0 is always 0.
- out_is_compressed_o  output  1  instruction is 16-bit.
- out_err_o  output  1  fetch error attached to this instruction.
- out_err_plus2_o  output  1  error came only from the second word of a straddling instruction.
- busy_o  output  1  the held halfword or the output register is valid.

## Operation
- State:
  - Held halfword: `hold_v`, `hold_data[15:0]`, `hold_addr[31:1]`, `hold_err`.
  - Output register: `out_v` plus the data fields.
- Compressed test: bits [1:0] != 2'b11.
- `advance` = ~out_v | out_ready_i. Nothing below happens unless `advance` is high and `clear_i` is low.
- Cases, evaluated in priority order:
  - A. `hold_v` and the held halfword is compressed:
    - Emit it: addr = hold_addr, compressed = 1, err = hold_err.
    - Clear `hold_v`.
    - Do not consume the input (`in_ready_o` = 0).
  - B. `hold_v`, held halfword uncompressed, and `in_valid_i`:
    - Emit {in_rdata_i[15:0], hold_data} with addr = hold_addr.
    - err = hold_err | in_err_i; err_plus2 = in_err_i & ~hold_err.
    - Consume the word.
    - Reload the hold register with in_rdata_i[31:16], addr in_addr_i+2, err in_err_i.
  - C. `hold_v`, held halfword uncompressed, no input: emit nothing; keep holding.
  - D. ~hold_v, `in_valid_i`, in_addr_i[1] = 0:
    - Low half compressed: emit in_rdata_i[15:0]; load the hold register with the upper half (addr +2, err in_err_i).
    - Low half uncompressed: emit the full word; `hold_v` stays 0.
    - Consume the word in both sub-cases.
  - E. ~hold_v, `in_valid_i`, in_addr_i[1] = 1:
    - Upper half compressed: emit in_rdata_i[31:16] with addr = in_addr_i.
    - Upper half uncompressed: load it into the hold register.
    - Consume the word in both sub-cases.
- Output register update:
  - If `advance` and a case emits: `out_v` <= 1 and all fields load.
  - Else if `out_ready_i`: `out_v` <= 0.
- `clear_i` has priority over everything:
  - Next cycle: `out_v` = 0 and `hold_v` = 0.
  - `in_ready_o` = 0 in the clear cycle.
  - Input presented in the clear cycle is not consumed. The word is not lost: it stays on the input for the following cycle, and the upstream clears on the same branch.
- Error words: a compressed/uncompressed decision is still made from the (garbage) data; the error flag travels with the instruction. Downstream treats any instruction with `out_err_o` set as faulting.
- Stream rule: when `hold_v` is set, the next input word is sequential, with in_addr_i = hold_addr + 2 and bit 1 = 0. This is asserted in the bench, not checked in RTL.

## Timing
- Reset (sync, rst_ni = 0 at the clock edge):
  - `out_valid_o`, `out_rdata_o`, `out_addr_o`, `out_is_compressed_o`, `out_err_o`, `out_err_plus2_o`, `busy_o` all 0.
  - `hold_v` = 0.
  - `in_ready_o` = 0 while in reset.
- Reset mid-operation behaves exactly like `clear_i`, plus the output fields are zeroed.
- Latency: word accepted in cycle N produces its instruction at `out_valid_o` in N+1.
- Throughput: one instruction per cycle.
  - A fully compressed aligned stream consumes one word every 2 cycles (case D, then case A).
- `in_ready_o` is combinational from `advance`, `clear_i`, the hold state, `in_valid_i` and `in_addr_i`. It never depends on `in_rdata_i` through the output path, except via the compressed test on the held halfword.
- Backpressure: while out_v & ~out_ready_i, all state is frozen and `in_ready_o` = 0.
- No combinational path from `in_*` to `out_*`.

## Test plan
- Aligned 32-bit stream: words 0x00000013 at 0x100, 0x00100093 at 0x104, out_ready_i = 1 throughout.
  - Out in N+1 / N+2: addrs 0x100 / 0x104, compressed 0, one word consumed per cycle.
- Compressed pair: word 0x00010001 at 0x200.
  - Out 0x0001 at 0x200, then 0x0001 at 0x202 on consecutive cycles.
  - Word consumed in the first cycle; `in_ready_o` = 0 in the second.
- Straddling instruction:
  - Inputs: word 0x00130001 at 0x300, then 0xABCD0000 at 0x304.
  - Out: 0x0001 at 0x300 (c), then 0x00000013 at 0x302 (32-bit), then held 0xABCD evaluated.
  - With in_err_i = 1 on the second word only: the 0x302 instruction has out_err_o = 1 and out_err_plus2_o = 1.
- Branch to a halfword address: clear_i pulse, then word 0x00930001 at 0x402 (addr bit1 = 1).
  - Upper half 0x0093 is uncompressed, so it is held and nothing is emitted.
  - The next word at 0x404 completes the 0x402 instruction.
- Backpressure plus clear:
  - Hold out_ready_i = 0 for 3 cycles: outputs stable, `in_ready_o` = 0.
  - Assert clear_i with `hold_v` = 1: next cycle `out_valid_o` = 0, `busy_o` = 0.
  - Repeat with rst_ni = 0 mid-stream: all outputs 0 after one edge.
